// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipeline:
// ALU opcodes, EX FSM states, register sentinel.
package cpu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOT  = 4'd5;
    localparam logic [3:0] ALU_SLL  = 4'd6;
    localparam logic [3:0] ALU_SRL  = 4'd7;
    localparam logic [3:0] ALU_SRA  = 4'd8;
    localparam logic [3:0] ALU_SLT  = 4'd9;
    localparam logic [3:0] ALU_SLTU = 4'd10;
    localparam logic [3:0] ALU_CMP  = 4'd11;
    localparam logic [3:0] ALU_PSA  = 4'd12;
    localparam logic [3:0] ALU_PSB  = 4'd13;
    localparam logic [3:0] ALU_MUL  = 4'd14;
    localparam logic [3:0] ALU_DIV  = 4'd15;

    localparam logic [3:0] REG_NONE = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } ex_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative unsigned multiply / restoring divide,
// one bit per cycle over MD_CYCLES cycles.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MD_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             abort,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    // MUL: r_a multiplicand, r_b multiplier, r_acc product
    // DIV: r_a dividend/quotient, r_b divisor, r_acc remainder
    logic [CW-1:0]    r_cnt;
    logic             r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_acc;

    logic [WIDTH:0]   w_rs;
    logic [WIDTH:0]   w_diff;
    logic             w_ge;

    assign w_rs   = {r_acc, r_a[WIDTH-1]};
    assign w_diff = w_rs - {1'b0, r_b};
    assign w_ge   = (w_rs >= {1'b0, r_b});

    assign done   = (r_cnt == CW'(1));
    assign result = r_op ? r_a : r_acc;

    // Load operands on start, then one shift step per cycle
    always_ff @(posedge CLK) begin
        if (RST || abort) begin
            r_cnt <= '0;
            r_op  <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
            r_acc <= '0;
        end else if (start) begin
            r_cnt <= CW'(MD_CYCLES);
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_acc <= '0;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
            if (r_op) begin
                r_a <= {r_a[WIDTH-2:0], w_ge};
                r_acc <= w_ge ? w_diff[WIDTH-1:0]
                              : w_rs[WIDTH-1:0];
            end else begin
                if (r_b[0])
                    r_acc <= r_acc + r_a;
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
            end
        end
    end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, mul/div sequencing
// FSM and the EX/MEM output register.
module ex_stage
    import cpu_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int MD_CYCLES = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             regwrite_i,
    input  logic             memtoreg_i,
    input  logic             memread_i,
    input  logic             memwrite_i,
    input  logic [3:0]       aluop_i,
    input  logic [WIDTH-1:0] alusrc1_i,
    input  logic [WIDTH-1:0] alusrc2_i,
    input  logic [WIDTH-1:0] memdata_i,
    input  logic [3:0]       regdst_i,
    input  logic [WIDTH-1:0] epc_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             regwrite_o,
    output logic             memtoreg_o,
    output logic             memread_o,
    output logic             memwrite_o,
    output logic [WIDTH-1:0] aluresult_o,
    output logic [WIDTH-1:0] memdata_o,
    output logic [3:0]       regdst_o,
    output logic [WIDTH-1:0] epc_o,
    output logic             busy_o
);

    ex_state_e        r_state;
    logic [WIDTH-1:0] w_alu;
    logic [WIDTH-1:0] w_md_res;
    logic             w_md_done;
    logic             w_is_md;
    logic             w_start;

    assign w_is_md = (aluop_i == ALU_MUL) || (aluop_i == ALU_DIV);
    assign w_start = (r_state == ST_IDLE) && w_is_md && !flush_i;
    assign stall_o = !flush_i &&
                     (((r_state == ST_IDLE) && w_is_md) ||
                      (r_state == ST_BUSY));
    assign busy_o  = (r_state != ST_IDLE);

    muldiv_unit #(
        .WIDTH     (WIDTH),
        .MD_CYCLES (MD_CYCLES)
    ) u_muldiv (
        .CLK    (CLK),
        .RST    (RST),
        .start  (w_start),
        .abort  (flush_i),
        .op     (aluop_i == ALU_DIV),
        .a      (alusrc1_i),
        .b      (alusrc2_i),
        .done   (w_md_done),
        .result (w_md_res)
    );

    // Single-cycle ALU datapath
    always_comb begin
        w_alu = '0;
        case (aluop_i)
            ALU_ADD:  w_alu = alusrc1_i + alusrc2_i;
            ALU_SUB:  w_alu = alusrc1_i - alusrc2_i;
            ALU_AND:  w_alu = alusrc1_i & alusrc2_i;
            ALU_OR:   w_alu = alusrc1_i | alusrc2_i;
            ALU_XOR:  w_alu = alusrc1_i ^ alusrc2_i;
            ALU_NOT:  w_alu = ~alusrc1_i;
            ALU_SLL:  w_alu = alusrc1_i << alusrc2_i[3:0];
            ALU_SRL:  w_alu = alusrc1_i >> alusrc2_i[3:0];
            ALU_SRA:  w_alu = $unsigned($signed(alusrc1_i)
                                        >>> alusrc2_i[3:0]);
            ALU_SLT:  w_alu = ($signed(alusrc1_i) < $signed(alusrc2_i))
                              ? WIDTH'(1) : '0;
            ALU_SLTU: w_alu = (alusrc1_i < alusrc2_i)
                              ? WIDTH'(1) : '0;
            ALU_CMP:  w_alu = (alusrc1_i == alusrc2_i)
                              ? '0 : WIDTH'(1);
            ALU_PSA:  w_alu = alusrc1_i;
            ALU_PSB:  w_alu = alusrc2_i;
            default:  w_alu = '0;
        endcase
    end

    // IDLE -> BUSY on mul/div start, BUSY -> DONE on last step
    always_ff @(posedge CLK) begin
        if (RST || flush_i) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_is_md) r_state <= ST_BUSY;
                ST_BUSY: if (w_md_done) r_state <= ST_DONE;
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // EX/MEM register: bubble on flush/stall, data holds
    always_ff @(posedge CLK) begin
        if (RST) begin
            regwrite_o  <= 1'b0;
            memtoreg_o  <= 1'b0;
            memread_o   <= 1'b0;
            memwrite_o  <= 1'b0;
            regdst_o    <= REG_NONE;
            aluresult_o <= '0;
            memdata_o   <= '0;
            epc_o       <= '0;
        end else if (flush_i || stall_o) begin
            regwrite_o  <= 1'b0;
            memtoreg_o  <= 1'b0;
            memread_o   <= 1'b0;
            memwrite_o  <= 1'b0;
            regdst_o    <= REG_NONE;
        end else begin
            regwrite_o  <= regwrite_i;
            memtoreg_o  <= memtoreg_i;
            memread_o   <= memread_i;
            memwrite_o  <= memwrite_i;
            regdst_o    <= regdst_i;
            aluresult_o <= (r_state == ST_DONE) ? w_md_res : w_alu;
            memdata_o   <= memdata_i;
            epc_o       <= epc_i;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: expected EX/MEM
// contents queued at drive time, popped after each edge.
module tb_ex_stage;
    import cpu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        regwrite_i = 0, memtoreg_i = 0;
    logic        memread_i = 0, memwrite_i = 0;
    logic [3:0]  aluop_i = ALU_PSB;
    logic [15:0] alusrc1_i = 0, alusrc2_i = 0;
    logic [15:0] memdata_i = 0, epc_i = 0;
    logic [3:0]  regdst_i = REG_NONE;
    logic        flush_i = 0;
    logic        stall_o, busy_o;
    logic        regwrite_o, memtoreg_o, memread_o, memwrite_o;
    logic [15:0] aluresult_o, memdata_o, epc_o;
    logic [3:0]  regdst_o;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a, b, md, epc;
        logic [3:0]  rd;
        logic [3:0]  ctl;
    } ins_t;

    typedef struct {
        logic [3:0]  ctl;
        logic [3:0]  rd;
        logic        dchk;
        logic [15:0] res, md, epc;
    } exp_t;

    exp_t q[$];

    ex_stage #(.WIDTH(16), .MD_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i),
        .memread_i(memread_i), .memwrite_i(memwrite_i),
        .aluop_i(aluop_i), .alusrc1_i(alusrc1_i),
        .alusrc2_i(alusrc2_i), .memdata_i(memdata_i),
        .regdst_i(regdst_i), .epc_i(epc_i), .flush_i(flush_i),
        .stall_o(stall_o), .regwrite_o(regwrite_o),
        .memtoreg_o(memtoreg_o), .memread_o(memread_o),
        .memwrite_o(memwrite_o), .aluresult_o(aluresult_o),
        .memdata_o(memdata_o), .regdst_o(regdst_o),
        .epc_o(epc_o), .busy_o(busy_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ref_alu(input logic [3:0] op,
                                            input logic [15:0] a,
                                            input logic [15:0] b);
        logic [31:0] p;
        logic signed [15:0] sa;
        sa = a;
        p  = {16'h0, a} * {16'h0, b};
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return ~a;
            6:  return a << b[3:0];
            7:  return a >> b[3:0];
            8:  return sa >>> b[3:0];
            9:  return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            10: return (a < b) ? 16'd1 : 16'd0;
            11: return (a == b) ? 16'd0 : 16'd1;
            12: return a;
            13: return b;
            14: return p[15:0];
            default: return (b == 0) ? 16'hFFFF : a / b;
        endcase
    endfunction

    function automatic ins_t mk(input logic [3:0] op,
                                input logic [15:0] a,
                                input logic [15:0] b,
                                input logic [3:0] rd,
                                input logic [3:0] ctl);
        ins_t s;
        s.op  = op;
        s.a   = a;
        s.b   = b;
        s.rd  = rd;
        s.ctl = ctl;
        s.md  = b ^ 16'hA5A5;
        s.epc = a + 16'h0100;
        return s;
    endfunction

    task automatic drive(input ins_t s, input logic fl,
                         input logic bub, input logic [15:0] res,
                         input logic est, input logic ebusy);
        exp_t e;
        @(negedge CLK);
        aluop_i   = s.op;
        alusrc1_i = s.a;
        alusrc2_i = s.b;
        memdata_i = s.md;
        epc_i     = s.epc;
        regdst_i  = s.rd;
        flush_i   = fl;
        {regwrite_i, memtoreg_i, memread_i, memwrite_i} = s.ctl;
        e.ctl  = bub ? 4'h0 : s.ctl;
        e.rd   = bub ? REG_NONE : s.rd;
        e.dchk = !bub;
        e.res  = res;
        e.md   = s.md;
        e.epc  = s.epc;
        q.push_back(e);
        #1;
        check("stall", stall_o, est);
        check("busy", busy_o, ebusy);
    endtask

    task automatic alu_op(input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] rd,
                          input logic [3:0] ctl, input logic [15:0] r);
        drive(mk(op, a, b, rd, ctl), 1'b0, 1'b0, r, 1'b0, 1'b0);
    endtask

    task automatic md_op(input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [3:0] rd,
                         input logic [15:0] r);
        ins_t s;
        s = mk(op, a, b, rd, 4'b1000);
        for (int i = 0; i < 18; i++)
            drive(s, 1'b0, i < 17, r, i < 17, i != 0);
    endtask

    task automatic check_reset();
        check("rst_ctl",
              {regwrite_o, memtoreg_o, memread_o, memwrite_o}, 0);
        check("rst_rd", regdst_o, 4'hF);
        check("rst_res", aluresult_o, 0);
        check("rst_md", memdata_o, 0);
        check("rst_epc", epc_o, 0);
        check("rst_stall", stall_o, 0);
        check("rst_busy", busy_o, 0);
    endtask

    initial begin : mon
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                check("ctl", {regwrite_o, memtoreg_o,
                              memread_o, memwrite_o}, e.ctl);
                check("rd", regdst_o, e.rd);
                if (e.dchk) begin
                    check("res", aluresult_o, e.res);
                    check("mdata", memdata_o, e.md);
                    check("epc", epc_o, e.epc);
                end
            end
        end
    end

    initial begin : stim
        ins_t s;
        logic [3:0]  op;
        logic [15:0] a, b;

        repeat (2) @(negedge CLK);
        check_reset();
        RST = 1'b0;

        alu_op(ALU_ADD, 16'hFFFF, 16'h0002, 4'd3, 4'b1000, 16'h0001);
        alu_op(ALU_SRA, 16'h8000, 16'h0004, 4'd4, 4'b1000, 16'hF800);
        alu_op(ALU_SLT, 16'hFFFF, 16'h0001, 4'd5, 4'b1000, 16'h0001);
        alu_op(ALU_SLTU, 16'hFFFF, 16'h0001, 4'd5, 4'b1000, 16'h0000);
        alu_op(ALU_CMP, 16'h1234, 16'h1234, 4'd6, 4'b0000, 16'h0000);
        alu_op(ALU_ADD, 16'h0010, 16'h0004, 4'd0, 4'b0110, 16'h0014);
        alu_op(ALU_PSA, 16'hBEEF, 16'h0000, 4'd0, 4'b0001, 16'hBEEF);

        md_op(ALU_MUL, 16'd300, 16'd500, 4'd7, 16'h49F0);
        md_op(ALU_MUL, 16'd300, 16'd500, 4'd7, 16'h49F0);
        md_op(ALU_DIV, 16'd1000, 16'd7, 4'd8, 16'd142);
        md_op(ALU_DIV, 16'd5, 16'd0, 4'd9, 16'hFFFF);

        for (int k = 0; k < 24; k++) begin
            op = 4'($urandom_range(0, 13));
            a  = 16'($urandom);
            b  = 16'($urandom);
            alu_op(op, a, b, 4'($urandom_range(0, 14)),
                   4'($urandom), ref_alu(op, a, b));
        end
        for (int k = 0; k < 4; k++) begin
            op = (k % 2 == 0) ? ALU_MUL : ALU_DIV;
            a  = 16'($urandom);
            b  = 16'($urandom_range(0, 300));
            md_op(op, a, b, 4'd10, ref_alu(op, a, b));
        end

        s = mk(ALU_MUL, 16'd300, 16'd500, 4'd7, 4'b1000);
        for (int i = 0; i < 9; i++)
            drive(s, 1'b0, 1'b1, 16'h0, 1'b1, i != 0);
        drive(s, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
        alu_op(ALU_ADD, 16'd20, 16'd22, 4'd2, 4'b1000, 16'd42);
        alu_op(ALU_PSB, 16'd0, 16'h0055, 4'hF, 4'b0000, 16'h0055);

        s = mk(ALU_DIV, 16'd99, 16'd3, 4'd2, 4'b1000);
        drive(s, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        alu_op(ALU_SUB, 16'd5, 16'd7, 4'd2, 4'b1000, 16'hFFFE);

        s = mk(ALU_MUL, 16'd9, 16'd9, 4'd2, 4'b1000);
        for (int i = 0; i < 17; i++)
            drive(s, 1'b0, 1'b1, 16'h0, 1'b1, i != 0);
        drive(s, 1'b1, 1'b1, 16'h0, 1'b0, 1'b1);
        alu_op(ALU_OR, 16'h0F00, 16'h00F0, 4'd1, 4'b1000, 16'h0FF0);

        s = mk(ALU_MUL, 16'd300, 16'd500, 4'd7, 4'b1000);
        for (int i = 0; i < 6; i++)
            drive(s, 1'b0, 1'b1, 16'h0, 1'b1, i != 0);
        @(negedge CLK);
        RST = 1'b1;
        aluop_i = ALU_PSB;
        {regwrite_i, memtoreg_i, memread_i, memwrite_i} = 4'h0;
        regdst_i = REG_NONE;
        @(negedge CLK);
        check_reset();
        RST = 1'b0;
        for (int i = 0; i < 20; i++)
            alu_op(ALU_PSB, 16'd0, 16'(i), 4'hF, 4'h0, 16'(i));

        repeat (3) @(negedge CLK);
        check("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 16-bit five-stage pipeline. It sits directly downstream of the ID/EX pipeline register and consumes its operand, control and destination fields. Single-cycle ALU operations complete in one cycle. MUL and DIV run on an iterative 16-cycle engine that stalls upstream. Results and the control bundle are registered into the EX/MEM boundary for the memory stage.

## Interface
Parameters:
- WIDTH, 16, datapath width
- MD_CYCLES, 16, iterations of the mul/div engine; must equal WIDTH

Ports:
- CLK  in  1  single clock, rising edge
- RST  in  1  reset, synchronous, active-high
- regwrite_i, memtoreg_i, memread_i, memwrite_i  in  1 each  control bits from ID/EX
- aluop_i  in  4  operation code
- alusrc1_i, alusrc2_i  in  16  ALU operands A, B (already forwarded)
- memdata_i  in  16  store data
- regdst_i  in  4  destination register; 4'b1111 means none
- epc_i  in  16  exception PC of the instruction
- flush_i  in  1  kill the instruction currently in EX
- stall_o  out  1  hold ID/EX and earlier stages this cycle (combinational)
- regwrite_o, memtoreg_o, memread_o, memwrite_o  out  1 each  registered control
- aluresult_o  out  16  registered result or memory address
- memdata_o  out  16  registered store data
- regdst_o  out  4  registered destination
- epc_o  out  16  registered EPC
- busy_o  out  1  FSM not IDLE (debug and hazard use)

## Operation
aluop encoding:
- 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT A
- 6 SLL, 7 SRL, 8 SRA; shift amount is B[3:0]
- 9 SLT (signed; result 1 or 0), 10 SLTU, 11 CMP (0 if A==B, else 1)
- 12 PASS A, 13 PASS B, 14 MUL (low 16 bits, unsigned), 15 DIV (unsigned quotient)

Arithmetic:
- ADD and SUB wrap modulo 2^16.
- DIV with B==0 yields 16'hFFFF.

FSM states: IDLE, BUSY, DONE.
- IDLE, non-mul/div instruction: compute combinationally, register outputs at the next edge.
- IDLE, MUL or DIV, no flush:
  - capture A and B into the engine, load count=MD_CYCLES, go to BUSY
  - stall_o=1; register a bubble
- BUSY: one shift-add (MUL) or restoring-subtract (DIV) step per cycle, count decrements.
  - stall_o=1; register a bubble each cycle
  - when count reaches 1, go to DONE
- DONE: stall_o=0.
  - register the engine result with the control, memdata, regdst and epc fields currently on the inputs; ID/EX has held the same instruction throughout
  - go to IDLE

Bubble: all four control bits 0, regdst_o=4'b1111; data outputs are don't-care but deterministic (hold previous value).

Flush:
- flush_i=1 in any state registers a bubble, forces IDLE and forces stall_o=0.
- Flush takes priority over starting or finishing a mul/div.

## Timing
- Reset values: all control outputs 0, regdst_o 4'b1111, aluresult_o/memdata_o/epc_o 16'h0000, stall_o 0, busy_o 0, FSM IDLE.
- RST asserted mid-BUSY aborts the operation at that edge.
- Single-cycle op: inputs valid in cycle N, outputs valid after edge N+1.
- MUL/DIV presented in cycle N:
  - stall_o high in cycles N..N+16 (17 cycles)
  - DONE in cycle N+17
  - result visible after edge N+18
- Back-to-back MUL: the second MUL is seen in IDLE in the cycle after DONE and restarts with no gap cycle.
- stall_o depends only on state, aluop_i and flush_i; no path from the outputs.

## Structure
- Shared package `cpu_pkg`: aluop localparams, FSM state encoding, REG_NONE=4'b1111.
- Sub-module `muldiv_unit`:
  - ports: start, op, a, b, count/done, result
  - holds the accumulator, remainder and shift registers
- ex_stage keeps the combinational ALU, the FSM and the EX/MEM output registers.

## Test plan
- Reset: hold RST for 2 cycles -> all outputs at reset values, regdst_o=4'hF, stall_o=0.
- ADD A=16'hFFFF, B=16'h0002, regdst=3, regwrite=1 -> next cycle aluresult_o=16'h0001, regwrite_o=1, regdst_o=3; SRA A=16'h8000, B=4 -> 16'hF800.
- MUL A=300, B=500:
  - stall_o high for exactly 17 cycles
  - bubbles on the outputs during the stall
  - then aluresult_o=16'h49F0 (150000 mod 65536)
- DIV A=1000, B=7 -> 142; DIV A=5, B=0 -> 16'hFFFF; each shows the same 17-cycle stall.
- Flush at BUSY count=8:
  - bubble registered, stall_o drops the same cycle
  - busy_o=0 the next cycle
  - a following ADD completes normally
- RST pulsed mid-MUL -> FSM returns to IDLE, outputs at reset values, no late result appears.
